// File: rtl/mem_ctrl_pkg.sv
// Shared types for the byte-serial memory controller: widths, FSM encoding,
// latched request record and little-endian byte helpers.
package mem_ctrl_pkg;

   localparam int MemAddrW = 32;
   localparam int MemDataW = 32;
   localparam int MemByteW = 8;
   localparam int MemLenW  = 2;
   localparam int MemCntW  = 3;

   typedef logic [MemAddrW-1:0] mem_addr_t;
   typedef logic [MemDataW-1:0] mem_data_t;
   typedef logic [MemByteW-1:0] mem_byte_t;
   typedef logic [MemLenW-1:0]  mem_len_t;
   typedef logic [MemCntW-1:0]  mem_cnt_t;

   typedef enum logic [1:0] {
      MemIdle  = 2'd0,
      MemRead  = 2'd1,
      MemWrite = 2'd2
   } mem_state_t;

   typedef enum logic {
      OwnerI = 1'b0,
      OwnerD = 1'b1
   } mem_owner_t;

   // Everything captured at grant; requester inputs are ignored afterwards.
   typedef struct packed {
      mem_owner_t owner;
      mem_addr_t  base;
      mem_cnt_t   n;
      mem_data_t  wdata;
   } mem_req_t;

   // The undefined length code 2 is served as a full word.
   function automatic mem_cnt_t len_to_bytes(input mem_len_t len);
      mem_cnt_t n;
      case (len)
         2'd0:    n = 3'd1;
         2'd1:    n = 3'd2;
         default: n = 3'd4;
      endcase
      return n;
   endfunction

   function automatic mem_data_t merge_byte(input mem_data_t word,
                                            input logic [1:0] idx,
                                            input mem_byte_t b);
      mem_data_t r;
      r = word;
      r[{idx, 3'b000} +: 8] = b;
      return r;
   endfunction

   function automatic mem_byte_t pick_byte(input mem_data_t word,
                                           input logic [1:0] idx);
      return word[{idx, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates icache and data requests onto an 8-bit RAM, one byte per cycle;
// word read ready 5 edges after grant, writes N+0. Requesters see busy, no queueing.
module mem_ctrl
   import mem_ctrl_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        i_read,
   input  logic [31:0] i_addr,
   output logic        i_busy,
   output logic        i_ready,
   output logic [31:0] i_data,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [31:0] d_addr,
   input  logic [1:0]  d_len,
   input  logic [31:0] d_wdata,
   output logic        d_busy,
   output logic        d_ready,
   output logic [31:0] d_rdata,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   output logic [7:0]  mem_dout,
   input  logic [7:0]  mem_din
);

   mem_state_t state_q;
   mem_state_t state_d;
   mem_req_t   req_q;
   mem_cnt_t   cnt_q;
   mem_cnt_t   cap_q;
   logic       addr_vld_q;
   logic       din_vld_q;
   mem_data_t  buf_q;
   mem_data_t  rd_word;

   logic grant_wr;
   logic grant_rd_d;
   logic grant_rd_i;
   logic issue;
   logic capture;
   logic read_done;
   logic write_done;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= MemIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         MemIdle: begin
            if (d_write) begin
               state_d = MemWrite;
            end else if (d_read || i_read) begin
               state_d = MemRead;
            end
         end
         MemRead: begin
            if (read_done) begin
               state_d = MemIdle;
            end
         end
         MemWrite: begin
            if (write_done) begin
               state_d = MemIdle;
            end
         end
         default: state_d = MemIdle;
      endcase
   end

   // Read bytes arrive one cycle after their address, so capture trails
   // issue by two stages and the read finishes on the last capture.
   always_comb begin
      grant_wr   = 1'b0;
      grant_rd_d = 1'b0;
      grant_rd_i = 1'b0;
      issue      = 1'b0;
      capture    = 1'b0;
      read_done  = 1'b0;
      write_done = 1'b0;
      case (state_q)
         MemIdle: begin
            grant_wr   = d_write;
            grant_rd_d = !d_write && d_read;
            grant_rd_i = !d_write && !d_read && i_read;
         end
         MemRead: begin
            issue     = (cnt_q < req_q.n);
            capture   = din_vld_q;
            read_done = din_vld_q && (cap_q == req_q.n - 3'd1);
         end
         MemWrite: begin
            issue      = (cnt_q < req_q.n);
            write_done = (cnt_q >= req_q.n);
         end
         default: ;
      endcase
   end

   assign rd_word = merge_byte(buf_q, cap_q[1:0], mem_din);

   assign d_busy = (state_q != MemIdle);
   assign i_busy = (state_q != MemIdle) | d_read | d_write;

   always_ff @(posedge clock) begin
      if (reset) begin
         req_q      <= '0;
         cnt_q      <= '0;
         cap_q      <= '0;
         addr_vld_q <= 1'b0;
         din_vld_q  <= 1'b0;
         buf_q      <= '0;
         mem_a      <= '0;
         mem_wr     <= 1'b0;
         mem_dout   <= '0;
         i_ready    <= 1'b0;
         i_data     <= '0;
         d_ready    <= 1'b0;
         d_rdata    <= '0;
      end else begin
         i_ready    <= 1'b0;
         d_ready    <= 1'b0;
         addr_vld_q <= 1'b0;
         din_vld_q  <= addr_vld_q;

         // Byte 0 goes on the bus straight from the grant edge.
         if (grant_wr || grant_rd_d || grant_rd_i) begin
            req_q.owner <= grant_rd_i ? OwnerI : OwnerD;
            req_q.base  <= grant_rd_i ? i_addr : d_addr;
            req_q.n     <= grant_rd_i ? 3'd4 : len_to_bytes(d_len);
            req_q.wdata <= d_wdata;
            cnt_q       <= 3'd1;
            cap_q       <= '0;
            buf_q       <= '0;
            mem_a       <= grant_rd_i ? i_addr : d_addr;
            mem_wr      <= grant_wr;
            mem_dout    <= grant_wr ? d_wdata[7:0] : 8'h00;
            addr_vld_q  <= !grant_wr;
         end

         if (issue) begin
            mem_a      <= req_q.base + {{(MemAddrW-MemCntW){1'b0}}, cnt_q};
            cnt_q      <= cnt_q + 3'd1;
            addr_vld_q <= (state_q == MemRead);
            if (state_q == MemWrite) begin
               mem_dout <= pick_byte(req_q.wdata, cnt_q[1:0]);
            end
         end

         if (write_done) begin
            mem_wr   <= 1'b0;
            mem_dout <= '0;
            d_ready  <= 1'b1;
         end

         if (capture) begin
            buf_q <= rd_word;
            cap_q <= cap_q + 3'd1;
         end

         if (read_done) begin
            if (req_q.owner == OwnerI) begin
               i_ready <= 1'b1;
               i_data  <= rd_word;
            end else begin
               d_ready <= 1'b1;
               d_rdata <= rd_word;
            end
         end
      end
   end

endmodule
